path_replay: RTL
================

Name: path_replay

Overview:
- Downstream consumer of the 2-bit move stack used by the maze/path solver.
- Once a solve completes, drains the stack via pop pulses and buffers the popped moves locally.
- Re-emits the moves in forward (push) order on a valid/ready stream for the display/motion stage.
- Reports the number of moves replayed and pulses done when finished.

Parameters:
- WIDTH, 2: move/data width; must match the stack WIDTH.
- LENGTH, 8: local buffer depth; must be ≥ the stack depth.
- CNT_W, 4: width of count; must hold the value LENGTH.
- POP_WAIT, 3: cycles (≥1) spent in WAIT between a stk_pop pulse and the sampling of stk_data/stk_empty.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin drain+replay; sampled only in IDLE
- stk_empty  in  1  stack empty flag
- stk_data  in  WIDTH  stack top/popped data
- stk_pop  out  1  one-cycle pop request to the stack
- move  out  WIDTH  replayed move
- move_valid  out  1  move is valid
- move_ready  in  1  consumer accepts move
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- count  out  CNT_W  entries captured in the last run

Behaviour:
- Reset: all outputs are 0: stk_pop, move, move_valid, busy, done, count. State goes to IDLE and the pointers clear. Reset wins over every other event, including mid-run; buffer contents are don't-care after reset.
- Registers: buf[0..LENGTH-1] of WIDTH bits, wr_ptr (capture index), rd_idx (emit index), wait counter.
- FSM states: IDLE, POP, WAIT, CAPTURE, EMIT, DONE.
- IDLE:
  - start=1 and stk_empty=1 → DONE; count<=0.
  - start=1 and stk_empty=0 → POP; wr_ptr<=0, count<=0.
  - Otherwise stay in IDLE.
- POP: stk_pop=1 for exactly this cycle; load the wait counter; → WAIT.
- WAIT: stay exactly POP_WAIT cycles, then → CAPTURE.
- CAPTURE:
  - buf[wr_ptr]<=stk_data; wr_ptr<=wr_ptr+1; count<=wr_ptr+1.
  - If stk_empty=1 (sampled this cycle) or wr_ptr+1==LENGTH → EMIT, with rd_idx<=wr_ptr. Otherwise → POP.
  - Pop-to-pop spacing is POP_WAIT+2 cycles.
- Order: buf[0] holds the last-pushed move, so emission runs from rd_idx=count-1 down to 0. This yields push order.
- EMIT:
  - move=buf[rd_idx] (registered output) and move_valid=1.
  - move and move_valid stay stable until move_valid&move_ready.
  - On handshake with rd_idx>0: rd_idx decrements and the next move appears the following cycle; move_valid stays 1 with no bubble required.
  - On handshake with rd_idx==0: move_valid<=0 and → DONE.
- DONE: done=1 for one cycle; → IDLE. count holds its value until the next accepted start.
- start while busy=1 is ignored with no side effects.
- stk_pop is never asserted outside POP, and is never asserted when the previously sampled stk_empty=1.
- Buffer full while the stack is non-empty: capture stops at LENGTH entries and the remaining stack contents are left untouched.
- No arithmetic wrap: wr_ptr ≤ LENGTH and rd_idx ≥ 0 are guaranteed by the FSM.
- move_ready outside EMIT is ignored.

Test Plan:
1. Stack pushed 2'b00,01,10,11; start pulse; move_ready=1 → exactly 4 stk_pop pulses spaced POP_WAIT+2=5 cycles apart. move stream is 00,01,10,11. count=4, single done pulse.
2. Empty stack; start → no stk_pop, no move_valid. busy is high for 1 cycle (DONE), done pulses the cycle after start, count=0.
3. 3 moves 11,10,01; move_ready high 1 cycle in every 3 → each move held stable while stalled. Output is 11,10,01 with no drop or duplicate.
4. Stack full with 8 moves 0,1,2,3,0,1,2,3 → 8 pops, then 8 moves in the same order. count=8, stk_empty=1 after the run.
5. rst asserted during EMIT after 2 accepted moves → next cycle move_valid=0, busy=0, count=0. A fresh start then completes normally.
6. Extra start pulses during POP/WAIT/EMIT → pop count, count value and move sequence are identical to a run with a single start.

Source files
------------

// File: rtl/path_replay_if.sv
// Stack-side pop handshake and replayed-move stream between path_replay and its neighbours.
// master = path_replay (pops the stack, drives moves); slave = stack + consumer side.
interface path_replay_if #(
  parameter int WIDTH = 2
);
  logic             stk_empty;
  logic [WIDTH-1:0] stk_data;
  logic             stk_pop;
  logic [WIDTH-1:0] move;
  logic             move_valid;
  logic             move_ready;

  modport master (
    input  stk_empty, stk_data, move_ready,
    output stk_pop, move, move_valid
  );

  modport slave (
    output stk_empty, stk_data, move_ready,
    input  stk_pop, move, move_valid
  );
endinterface

// File: rtl/path_replay.sv
// Drains the solver's move stack into a local buffer, then replays the moves in push order
// on a valid/ready stream; reports the captured count and pulses done at the end.
module path_replay #(
  parameter int WIDTH    = 2,
  parameter int LENGTH   = 8,
  parameter int CNT_W    = 4,
  parameter int POP_WAIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  path_replay_if.master    bus
);
  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int WT_W  = (POP_WAIT > 1) ? $clog2(POP_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_WAIT, S_CAPTURE, S_EMIT, S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] buf_q [LENGTH];
  logic [CNT_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] wr_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [WT_W-1:0]  wait_q;
  logic             stk_pop_q;
  logic             move_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] move_q;

  assign wr_ptr_d       = wr_ptr_q + CNT_W'(1);
  assign bus.stk_pop    = stk_pop_q;
  assign bus.move       = move_q;
  assign bus.move_valid = move_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign count          = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_idx_q     <= '0;
      wait_q       <= '0;
      count_q      <= '0;
      stk_pop_q    <= 1'b0;
      move_q       <= '0;
      move_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      stk_pop_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q <= '0;
            busy_q  <= 1'b1;
            if (bus.stk_empty) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_POP;
              wr_ptr_q  <= '0;
              stk_pop_q <= 1'b1;
            end
          end
        end
        S_POP: begin
          wait_q  <= WT_W'(POP_WAIT - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == '0) state_q <= S_CAPTURE;
          else              wait_q  <= wait_q - WT_W'(1);
        end
        S_CAPTURE: begin
          buf_q[wr_ptr_q[IDX_W-1:0]] <= bus.stk_data;
          wr_ptr_q <= wr_ptr_d;
          count_q  <= wr_ptr_d;
          if (bus.stk_empty || (wr_ptr_d == CNT_W'(LENGTH))) begin
            state_q      <= S_EMIT;
            rd_idx_q     <= wr_ptr_q[IDX_W-1:0];
            // First replayed move bypasses buf_q: that entry is only written on this edge.
            move_q       <= bus.stk_data;
            move_valid_q <= 1'b1;
          end else begin
            state_q   <= S_POP;
            stk_pop_q <= 1'b1;
          end
        end
        S_EMIT: begin
          if (bus.move_ready) begin
            if (rd_idx_q == '0) begin
              move_valid_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              rd_idx_q <= rd_idx_q - IDX_W'(1);
              move_q   <= buf_q[rd_idx_q - IDX_W'(1)];
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
